// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: mem_op field layout, op codes,
// access sizes and controller states.
package lsu_pkg;

    localparam int OP_STORE_BIT = 3;
    localparam int OP_UNS_BIT   = 2;
    localparam int OP_SIZE_MSB  = 1;
    localparam int OP_SIZE_LSB  = 0;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LD  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_LWU = 4'b0110;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [3:0] OP_SD  = 4'b1011;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    function automatic logic [1:0] op_size(input logic [3:0] op);
        return op[OP_SIZE_MSB:OP_SIZE_LSB];
    endfunction

endpackage

// File: rtl/lsu_mem_unit_if.sv
// Core-side request/response bundle and data-memory bus bundle for the LSU.
// In both, master is the side that raises the request.
interface lsu_req_if #(
    parameter int ADDR_W = 64,
    parameter int XLEN   = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        mem_op;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [XLEN-1:0]   rdata;

    modport master (output req_valid, mem_op, addr, wdata,
                    input  req_ready, resp_valid, resp_err, rdata);
    modport slave  (input  req_valid, mem_op, addr, wdata,
                    output req_ready, resp_valid, resp_err, rdata);
endinterface

interface lsu_bus_if #(
    parameter int ADDR_W = 64,
    parameter int XLEN   = 64
);
    logic              bus_req_valid;
    logic              bus_req_ready;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_wen;
    logic [7:0]        bus_wstrb;
    logic [XLEN-1:0]   bus_wdata;
    logic              bus_resp_valid;
    logic [XLEN-1:0]   bus_rdata;

    modport master (output bus_req_valid, bus_addr, bus_wen, bus_wstrb, bus_wdata,
                    input  bus_req_ready, bus_resp_valid, bus_rdata);
    modport slave  (input  bus_req_valid, bus_addr, bus_wen, bus_wstrb, bus_wdata,
                    output bus_req_ready, bus_resp_valid, bus_rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/data shifting, legality and alignment
// check, and load byte-field extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      op_i,
    input  logic [2:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] bus_rdata_i,
    output logic [7:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] load_o,
    output logic            err_o
);

    logic [1:0]      size;
    logic            uns;
    logic            illegal;
    logic            misaligned;
    logic [XLEN-1:0] field;

    assign size  = op_size(op_i);
    assign uns   = op_i[OP_UNS_BIT];
    assign field = bus_rdata_i >> {addr_lo_i, 3'b000};

    assign wdata_o = wdata_i << {addr_lo_i, 3'b000};
    assign err_o   = illegal | misaligned;

    always_comb begin
        illegal = 1'b0;
        if (op_i == 4'b0111 || op_i[3:2] == 2'b11) begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        misaligned = 1'b0;
        wstrb_o    = 8'h00;
        load_o     = '0;
        unique case (size)
            SZ_B: begin
                wstrb_o = 8'h01 << addr_lo_i;
                load_o  = uns ? {{(XLEN-8){1'b0}}, field[7:0]}
                              : {{(XLEN-8){field[7]}}, field[7:0]};
            end
            SZ_H: begin
                misaligned = addr_lo_i[0];
                wstrb_o    = 8'h03 << addr_lo_i;
                load_o     = uns ? {{(XLEN-16){1'b0}}, field[15:0]}
                                 : {{(XLEN-16){field[15]}}, field[15:0]};
            end
            SZ_W: begin
                misaligned = |addr_lo_i[1:0];
                wstrb_o    = 8'h0F << addr_lo_i;
                load_o     = uns ? {{(XLEN-32){1'b0}}, field[31:0]}
                                 : {{(XLEN-32){field[31]}}, field[31:0]};
            end
            SZ_D: begin
                misaligned = |addr_lo_i;
                wstrb_o    = 8'hFF;
                load_o     = field;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_unit.sv
// Multi-cycle load/store unit: accepts one memory op, runs a single 64-bit
// bus transfer (or rejects it), and returns a one-cycle completion pulse.
//
//   state   | meaning
//   IDLE    | ready for a request; request fields captured on accept
//   REQ     | bus request held stable until bus_req_ready
//   WAIT    | waiting for bus_resp_valid; load result captured
//   RESP    | resp_valid pulse, resp_err set for rejected ops
module lsu_mem_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int XLEN   = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  core,
    lsu_bus_if.master bus
);

    lsu_state_e        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [3:0]        al_op;
    logic [2:0]        al_addr_lo;
    logic [7:0]        al_wstrb;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_load;
    logic              al_err;

    logic              in_req;
    logic              in_resp;
    logic              is_store;

    // In IDLE the checker looks at the live request so the accept decision
    // needs no extra cycle; afterwards it works on the captured fields.
    assign al_op      = (state_q == ST_IDLE) ? core.mem_op    : op_q;
    assign al_addr_lo = (state_q == ST_IDLE) ? core.addr[2:0] : addr_q[2:0];

    lsu_align #(.XLEN(XLEN)) u_align (
        .op_i        (al_op),
        .addr_lo_i   (al_addr_lo),
        .wdata_i     (wdata_q),
        .bus_rdata_i (bus.bus_rdata),
        .wstrb_o     (al_wstrb),
        .wdata_o     (al_wdata),
        .load_o      (al_load),
        .err_o       (al_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (core.req_valid) begin
                    op_d    = core.mem_op;
                    addr_d  = core.addr;
                    wdata_d = core.wdata;
                    rdata_d = '0;
                    err_d   = al_err;
                    state_d = al_err ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.bus_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.bus_resp_valid) begin
                    if (!op_q[OP_STORE_BIT]) begin
                        rdata_d = al_load;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_req   = (state_q == ST_REQ);
    assign in_resp  = (state_q == ST_RESP);
    assign is_store = op_q[OP_STORE_BIT];

    assign core.req_ready  = (state_q == ST_IDLE);
    assign core.resp_valid = in_resp;
    assign core.resp_err   = in_resp & err_q;
    assign core.rdata      = in_resp ? rdata_q : '0;

    // Bus outputs are gated to REQ so they read as zero in every other state.
    assign bus.bus_req_valid = in_req;
    assign bus.bus_addr      = in_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign bus.bus_wen       = in_req & is_store;
    assign bus.bus_wstrb     = (in_req && is_store) ? al_wstrb : 8'h00;
    assign bus.bus_wdata     = (in_req && is_store) ? al_wdata : '0;

endmodule
